// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller state encoding, default bus widths and
// the opcode constants decoded by the control FSM.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Memory-stage controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

    // Opcodes decoded by the control FSM (top nibble of the instruction word)
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_LDW = 4'h8;
    localparam logic [3:0] OP_STW = 4'h9;
    localparam logic [3:0] OP_BRZ = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

endpackage

// File: rtl/mem_ctrl_lat_counter.sv
// Loadable 3-bit down-counter with a zero flag. Counts the RAM read latency
// while the controller waits in RD_WAIT; decrement saturates at zero.
module lat_counter (
    input  logic       CLK,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    // Load has priority over decrement; synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!reset)
            cnt <= 3'd0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/mem_ctrl.sv
// Memory access stage between the CPU control FSM and the unified RAM.
// Converts single-cycle MemRead/MemWrite strobes into a fixed-latency RAM
// handshake, steers read data into IR (fetch) or MDR (load), and holds busy
// while an access is in flight.
// Optional feature: define MEM_CTRL_BOUNDS_EN to reject accesses at or above
// MEM_WORDS (no RAM strobe, err set, normal busy/done timing, no IR/MDR update).
module mem_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = 2,
    parameter int MEM_WORDS = 256
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LDW_EN,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] ir_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    mem_state_t        state, state_nxt;
    logic              accept_rd, accept_wr, conflict;
    logic              capture, cnt_load, cnt_dec, cnt_zero;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] sel_addr;
    logic              oob;
    logic              tgt_mdr;   // latched LDW_EN: 1 = load into MDR
    logic              squash;    // latched out-of-range flag for this access

    assign rd_req   = MemRead & ~MemWrite;
    assign wr_req   = MemWrite & ~MemRead;
    // Stores always address data memory; reads follow LDW_EN
    assign sel_addr = (wr_req | LDW_EN) ? dmem_addr : pc;

`ifdef MEM_CTRL_BOUNDS_EN
    localparam logic [ADDR_W:0] WORDS_LIM = (ADDR_W+1)'(MEM_WORDS);
    assign oob = ({1'b0, sel_addr} >= WORDS_LIM);
`else
    assign oob = 1'b0;
`endif

    lat_counter u_lat (
        .CLK      (CLK),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; DONE accepts a new request just like IDLE
    always_comb begin
        state_nxt = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        conflict  = 1'b0;
        capture   = 1'b0;
        cnt_dec   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done      = (state == DONE);
                state_nxt = IDLE;
                if (rd_req) begin
                    accept_rd = 1'b1;
                    state_nxt = RD_WAIT;
                end else if (wr_req) begin
                    accept_wr = 1'b1;
                    state_nxt = WR;
                end else if (MemRead && MemWrite) begin
                    conflict = 1'b1;
                end
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        cnt_load = accept_rd;
    end

    // Request capture, RAM strobes, IR/MDR steering and sticky error
    always_ff @(posedge CLK) begin
        if (!reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ir_q      <= '0;
            mdr_q     <= '0;
            err       <= 1'b0;
            tgt_mdr   <= 1'b0;
            squash    <= 1'b0;
        end else begin
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            if (accept_rd || accept_wr) begin
                ram_addr <= sel_addr;
                tgt_mdr  <= LDW_EN;
                squash   <= oob;
                ram_re   <= accept_rd & ~oob;
                ram_we   <= accept_wr & ~oob;
                if (accept_wr)
                    ram_wdata <= wdata;
            end
            if (capture && !squash) begin
                if (tgt_mdr)
                    mdr_q <= ram_rdata;
                else
                    ir_q  <= ram_rdata;
            end
            if (conflict || ((accept_rd || accept_wr) && oob))
                err <= 1'b1;
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory access stage sitting directly downstream of the CPU control FSM and upstream of the unified instruction/data RAM.
- Turns the FSM's single-cycle MemRead/MemWrite/LDW_EN strobes into a multi-cycle handshake with a fixed-latency synchronous RAM.
- Steers read data into the IR (fetch) or MDR (load) holding register and raises `busy` so the FSM can stall.

Parameters:
- ADDR_W, 16, address width for pc, dmem_addr and ram_addr.
- DATA_W, 16, data word width.
- RD_LAT, 2, RAM read latency in cycles from ram_re to valid ram_rdata; legal range 1..7.
- MEM_WORDS, 256, number of implemented RAM words; used only by the optional bounds check.

Ports:
- CLK  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- MemRead  in  1  read request strobe from FSM.
- MemWrite  in  1  write request strobe from FSM.
- LDW_EN  in  1  address select: 0 = pc (instruction fetch), 1 = dmem_addr (data access).
- pc  in  ADDR_W  program counter.
- dmem_addr  in  ADDR_W  data address (register operand).
- wdata  in  DATA_W  store data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_re  out  1  RAM read enable, single-cycle pulse.
- ram_we  out  1  RAM write enable, single-cycle pulse.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_re.
- ir_q  out  DATA_W  instruction register contents.
- mdr_q  out  DATA_W  memory data register contents.
- busy  out  1  access in flight; FSM must not advance.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  sticky protocol/bounds error flag.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; ir_q, mdr_q, ram_addr and ram_wdata = 0; ram_re, ram_we, busy, done and err = 0; latency counter = 0. A reset during any access aborts it, and no IR/MDR update occurs.
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE: requests are sampled every cycle.
  - MemRead=1, MemWrite=0: register ram_addr = LDW_EN ? dmem_addr : pc. Pulse ram_re next cycle. Latch the target select (LDW_EN) internally. Load counter=RD_LAT. Go to RD_WAIT. busy=1 from the next cycle.
  - MemWrite=1, MemRead=0: register ram_addr = dmem_addr (regardless of LDW_EN) and ram_wdata = wdata. Go to WR. busy=1.
  - Both strobes high: request dropped, err set, stay in IDLE.
- RD_WAIT: counter decrements each cycle. When it reaches 0, ram_rdata is captured into ir_q (latched select=0) or mdr_q (latched select=1). Go to DONE.
- WR: ram_we=1 for exactly one cycle. Go to DONE.
- DONE: done=1 and busy=0 for one cycle. Return to IDLE; a new request may be sampled in this same cycle.
- Total latency:
  - Read: request cycle → done = RD_LAT+2 cycles.
  - Write: request cycle → done = 2 cycles.
- Strobes arriving in RD_WAIT or WR are ignored and do not set err; the FSM is responsible for holding them only while busy=0.
- ir_q and mdr_q hold their value between accesses and are never written by stores.
- Address and data are captured at accept; later changes to pc, dmem_addr or wdata have no effect on the access in flight.

Optional Feature:
- MEM_CTRL_BOUNDS_EN
- Defined: at accept, if the selected address >= MEM_WORDS, no ram_re/ram_we is issued, err is set, the FSM still sees busy, then done after the normal latency, and ir_q/mdr_q are unchanged.
- Undefined: no range check; addresses pass through unmodified and err is set only by simultaneous strobes.

Decomposition:
- Shared cpu_pkg: state encoding localparams (IDLE/RD_WAIT/WR/DONE), DATA_W/ADDR_W defaults, and the opcode constants already used by the FSM.
- One sub-module, lat_counter: loadable down-counter, 3 bits wide, with a zero flag, instantiated for RD_WAIT.

Test Plan:
- Reset hold: reset=0 for 3 cycles with MemRead=1 → no ram_re; ir_q=0; busy=0; err=0.
- Fetch: pc=0x0010, LDW_EN=0, MemRead pulse, RAM returns 0xA5C3 after RD_LAT=2 → ram_addr=0x0010; done pulses 4 cycles after the request; ir_q=0xA5C3; mdr_q unchanged.
- Load: dmem_addr=0x0042, LDW_EN=1, MemRead, RAM word 0x1234 → mdr_q=0x1234; ir_q unchanged; busy high for exactly RD_LAT+1 cycles.
- Store: dmem_addr=0x0007, wdata=0xBEEF, MemWrite → single ram_we cycle with ram_addr=0x0007 and ram_wdata=0xBEEF; done 2 cycles after the request.
- Conflict: MemRead=MemWrite=1 in IDLE → no RAM strobes; err=1 and remains set until reset. A mid-read reset (reset=0 during RD_WAIT) → state IDLE, ir_q=0, no done.
- Bounds (MEM_CTRL_BOUNDS_EN, MEM_WORDS=256): read at 0x0100 → no ram_re; err=1; done after the normal latency; ir_q unchanged.
